store_buffer: RTL and testbench
===============================

Name: store_buffer

Overview:
- Posted-write buffer between the CPU datapath and the single-port data memory (32 words, word index = Addr[4:0], asynchronous read, write on posedge).
- Accepts stores from the CPU in one cycle, queues them in a small FIFO, and drains them into the data memory when the memory port is not needed by a load.
- Loads read the memory directly. The youngest matching buffered store is forwarded so loads always see program-order data.

Parameters:
- DEPTH, 4, number of buffered stores (power of two, ≥2).
- AW, 5, address bits compared and driven to memory (matches the data memory index width).
- DW, 32, data width.

Ports:
- Clk  in  1  rising-edge clock.
- Rst  in  1  synchronous, active-high reset.
- Cpu_Addr  in  32  load/store byte-agnostic word address; bits [AW-1:0] used.
- Cpu_Din  in  DW  store data.
- Cpu_We  in  1  store request.
- Cpu_Re  in  1  load request.
- Ld_Dout  out  DW  load result, combinational.
- Stall  out  1  store not accepted this cycle; CPU holds the instruction.
- Mem_Addr  out  32  to data memory Addr; upper bits zero.
- Mem_Din  out  DW  to data memory Din.
- Mem_We  out  1  to data memory We.
- Mem_Dout  in  DW  from data memory Dout (asynchronous).
- Empty  out  1  buffer holds no stores (fence/halt wait).
- Count  out  $clog2(DEPTH+1)  occupancy.

Behaviour:
- State: entry array {addr[AW-1:0], data[DW-1:0]}, head/tail pointers (log2 DEPTH bits, wrap modulo DEPTH), and count.
- Reset (Rst sampled high at posedge): count=0, head=tail=0. Entry contents are don't-care. Any in-progress drain or queued stores are discarded.
- Outputs after reset: Empty=1, Count=0, Mem_We=0, Stall=0.
- full = (count==DEPTH), from the registered count only.
- Stall = Cpu_We & full. There is no bypass of a push into a slot freed in the same cycle.
- Push: Cpu_We & !full writes {Cpu_Addr[AW-1:0], Cpu_Din} at tail; tail+1 at the next edge.
- Drain (port arbitration, combinational):
  - Cpu_Re=1: Mem_Addr = Cpu_Addr[AW-1:0] zero-extended, Mem_We=0. No drain; the load owns the port.
  - Otherwise, count>0: Mem_Addr = head.addr, Mem_Din = head.data, Mem_We=1. Head+1 at the edge, so the memory write and the pop commit together.
  - Otherwise: Mem_We=0, Mem_Addr = Cpu_Addr[AW-1:0], Mem_Din=0.
- Count update: count + push − drain. Simultaneous push and drain leaves count unchanged. A full buffer with Cpu_We and no load drains this cycle and accepts the retried store next cycle.
- Load data:
  - Ld_Dout = data of the youngest valid entry with addr == Cpu_Addr[AW-1:0], else Mem_Dout.
  - "Youngest" means closest to tail − 1, walking back to head.
  - Only entries valid at the start of the cycle take part. A store pushed in the same cycle is not forwarded.
  - Ld_Dout is driven regardless of Cpu_Re; the consumer qualifies it.
- Cpu_We & Cpu_Re together: push per the rules above, and the load is served per the forwarding rule. Ordering is load-before-store.
- Wrap-around: pointers wrap from DEPTH−1 to 0. Forwarding must be correct across the wrap.
- Latency: store visible to loads in the cycle after acceptance. Memory update occurs at most DEPTH + (consecutive load cycles) cycles later.
- Address aliasing: comparison uses AW bits only, mirroring memory aliasing (addresses 1 and 33 alias).

Decomposition:
- Shared package sb_pkg:
  - sb_entry_t struct {addr, data}.
  - Default constants SB_DEPTH=4, SB_AW=5, SB_DW=32.
  - Function for pointer increment with wrap.
- One sub-module, sb_fwd_match: the DEPTH-way compare and youngest-match priority select. Inputs: entries, head, count, lookup address. Outputs: hit and data.

Test Plan:
- Memory model preloaded word1=3, word2=4. Load addr 1 with buffer empty → Ld_Dout=3, Mem_We=0, Mem_Addr=1.
- Store addr 2 data 0xAA, next cycle load addr 2 → Ld_Dout=0xAA (forwarded, memory still 4). Cycle after: Mem_We=1, Mem_Addr=2, Mem_Din=0xAA; then Empty=1 and memory word2=0xAA.
- Stores 5←0x11 then 5←0x22 queued, load addr 5 → Ld_Dout=0x22 (youngest wins). Load addr 37 → 0x22 (alias).
- Six back-to-back stores with Cpu_Re held high → Count reaches 4, Stall=1 on the 5th and 6th store. Drop Cpu_Re → drain resumes and stalled stores are accepted; final memory contents are in program order.
- Push and drain in the same cycle across pointer wrap (tail DEPTH−1→0) → Count unchanged, forwarding of the wrapped entry correct.
- Assert Rst with Count=3 mid-drain → next cycle Count=0, Empty=1, Mem_We=0. The un-drained words keep their old memory values.

Source files
------------

// File: rtl/sb_pkg.sv
// sb_pkg: shared types, default sizes and pointer helper for the store buffer.
//   sb_entry_t : one buffered store {addr, data}
//   ptr_inc    : ring-pointer increment with wrap modulo depth
package sb_pkg;
    localparam int SB_DEPTH = 4;
    localparam int SB_AW = 5;
    localparam int SB_DW = 32;
    typedef struct packed {
        logic [SB_AW-1:0] addr;
        logic [SB_DW-1:0] data;
    } sb_entry_t;
    function automatic int ptr_inc(input int p, input int depth);
        return (p + 1) % depth;
    endfunction
endpackage

// File: rtl/sb_fwd_match.sv
// sb_fwd_match: finds the youngest valid buffered store whose address matches a load.
//   entries : ring of buffered stores
//   head    : index of the oldest valid entry
//   count   : number of valid entries starting at head
//   addr    : load word address
//   hit     : some valid entry matches
//   data    : data of the youngest matching entry (zero when no hit)
module sb_fwd_match
    import sb_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int AW = SB_AW,
    parameter int DW = SB_DW,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  sb_entry_t       entries [DEPTH],
    input  logic [PW-1:0]   head,
    input  logic [CW-1:0]   count,
    input  logic [AW-1:0]   addr,
    output logic            hit,
    output logic [DW-1:0]   data
);
    logic [PW-1:0] idx;
    // Walk oldest to youngest so a later match overrides an earlier one.
    always_comb begin
        hit = 1'b0;
        data = '0;
        idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if (CW'(i) < count && entries[idx].addr == addr) begin
                hit = 1'b1;
                data = entries[idx].data;
            end
        end
    end
endmodule

// File: rtl/store_buffer.sv
// store_buffer: posted-write FIFO between the CPU and a single-port data memory.
//   Clk, Rst            : clock, synchronous active-high reset
//   Cpu_Addr/Din/We/Re  : CPU load/store request
//   Ld_Dout             : load result (youngest buffered store, else memory)
//   Stall               : store refused because the buffer is full
//   Mem_Addr/Din/We     : data memory port, Mem_Dout its asynchronous read data
//   Empty, Count        : occupancy status
module store_buffer
    import sb_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int AW = SB_AW,
    parameter int DW = SB_DW,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic [31:0]   Cpu_Addr,
    input  logic [DW-1:0] Cpu_Din,
    input  logic          Cpu_We,
    input  logic          Cpu_Re,
    output logic [DW-1:0] Ld_Dout,
    output logic          Stall,
    output logic [31:0]   Mem_Addr,
    output logic [DW-1:0] Mem_Din,
    output logic          Mem_We,
    input  logic [DW-1:0] Mem_Dout,
    output logic          Empty,
    output logic [CW-1:0] Count
);
    sb_entry_t entries [DEPTH];
    logic [PW-1:0] head, tail;
    logic [CW-1:0] count;
    logic full, push, drain, hit;
    logic [DW-1:0] fwd_data;

    assign full = count == CW'(DEPTH);
    assign push = Cpu_We & ~full;
    // A load owns the memory port; otherwise the oldest store drains.
    assign drain = ~Cpu_Re & (count != '0);
    assign Stall = Cpu_We & full;
    assign Mem_We = drain;
    assign Mem_Addr = 32'(drain ? entries[head].addr : Cpu_Addr[AW-1:0]);
    assign Mem_Din = drain ? entries[head].data : '0;
    assign Ld_Dout = hit ? fwd_data : Mem_Dout;
    assign Empty = count == '0;
    assign Count = count;

    sb_fwd_match #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fwd (
        .entries(entries),
        .head(head),
        .count(count),
        .addr(Cpu_Addr[AW-1:0]),
        .hit(hit),
        .data(fwd_data)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            head <= '0;
            tail <= '0;
            count <= '0;
        end else begin
            if (push) tail <= PW'(ptr_inc(32'(tail), DEPTH));
            if (drain) head <= PW'(ptr_inc(32'(head), DEPTH));
            count <= count + CW'(push) - CW'(drain);
        end
    end

    // Entry contents need no reset; only head/tail/count define validity.
    always_ff @(posedge Clk) begin
        if (push) entries[tail] <= '{addr: Cpu_Addr[AW-1:0], data: Cpu_Din};
    end
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: randomized and directed checks of store_buffer against a queue/array model.
module tb_store_buffer;
    logic Clk, Rst, Cpu_We, Cpu_Re, Stall, Mem_We, Empty;
    logic [31:0] Cpu_Addr, Cpu_Din, Ld_Dout, Mem_Addr, Mem_Din, Mem_Dout;
    logic [2:0] Count;
    logic init;
    logic [31:0] mem [32];

    typedef struct packed {logic [4:0] a; logic [31:0] d;} ent_t;
    ent_t q[$];
    logic [31:0] arch [32];
    logic [31:0] phys [32];
    int pushes;
    int checks = 0;
    int errors = 0;

    logic a_stall, a_mwe, a_empty, e_stall, e_mwe, e_empty, e_full, e_drain;
    logic [31:0] a_ld, a_maddr, a_mdin, e_ld, e_maddr, e_mdin;
    logic [2:0] a_count, e_count;

    store_buffer dut (
        .Clk(Clk), .Rst(Rst), .Cpu_Addr(Cpu_Addr), .Cpu_Din(Cpu_Din),
        .Cpu_We(Cpu_We), .Cpu_Re(Cpu_Re), .Ld_Dout(Ld_Dout), .Stall(Stall),
        .Mem_Addr(Mem_Addr), .Mem_Din(Mem_Din), .Mem_We(Mem_We),
        .Mem_Dout(Mem_Dout), .Empty(Empty), .Count(Count)
    );

    function automatic logic [31:0] pre(input int i);
        return i == 1 ? 32'd3 : i == 2 ? 32'd4 : 32'h1000 + 32'(i);
    endfunction

    initial Clk = 0;
    always #5 Clk = ~Clk;

    assign Mem_Dout = mem[Mem_Addr[4:0]];
    always @(posedge Clk) begin
        if (init) for (int i = 0; i < 32; i++) mem[i] <= pre(i);
        else if (Mem_We) mem[Mem_Addr[4:0]] <= Mem_Din;
    end

    // One CPU cycle: predict outputs from the model, capture DUT outputs, advance both.
    task automatic step(input logic we, input logic re, input logic [31:0] addr, input logic [31:0] din);
        Cpu_We = we; Cpu_Re = re; Cpu_Addr = addr; Cpu_Din = din;
        #1;
        e_full = q.size() == 4;
        e_stall = we && e_full;
        e_drain = !re && q.size() > 0;
        e_ld = arch[addr[4:0]];
        e_mwe = e_drain;
        e_maddr = e_drain ? {27'b0, q[0].a} : {27'b0, addr[4:0]};
        e_mdin = e_drain ? q[0].d : 32'b0;
        e_count = 3'(q.size());
        e_empty = q.size() == 0;
        a_ld = Ld_Dout; a_stall = Stall; a_mwe = Mem_We; a_maddr = Mem_Addr;
        a_mdin = Mem_Din; a_count = Count; a_empty = Empty;
        @(posedge Clk);
        if (e_drain) begin
            phys[q[0].a] = q[0].d;
            void'(q.pop_front());
        end
        if (we && !e_full) begin
            q.push_back('{addr[4:0], din});
            arch[addr[4:0]] = din;
            pushes++;
        end
        @(negedge Clk);
        Cpu_We = 0; Cpu_Re = 0;
    endtask

    task automatic settle(input string tag);
        int g = 0;
        while (q.size() > 0 && g < 20) begin
            step(0, 0, 0, 0);
            g++;
        end
        checks++;
        if (q.size() > 0 || Empty !== 1'b1) begin
            errors++;
            $display("FAIL %s_drain_timeout Empty=%0b required 1", tag, Empty);
        end
    endtask

    task automatic test_reset();
        Rst = 1; Cpu_We = 0; Cpu_Re = 1; Cpu_Addr = 0; Cpu_Din = 0;
        @(posedge Clk);
        q.delete();
        arch = phys;
        pushes = 0;
        @(negedge Clk);
        Rst = 0; Cpu_Re = 0; init = 0;
        #1;
        checks += 4;
        if (Count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", Count); end
        if (Empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %0b want 1", Empty); end
        if (Mem_We !== 1'b0) begin errors++; $display("FAIL reset_mem_we got %0b want 0", Mem_We); end
        if (Stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %0b want 0", Stall); end
    endtask

    task automatic test_directed();
        step(0, 1, 1, 0);
        checks += 3;
        if (a_ld !== 32'd3) begin errors++; $display("FAIL dir_load1 got %0h want 3", a_ld); end
        if (a_mwe !== 1'b0) begin errors++; $display("FAIL dir_load1_we got %0b want 0", a_mwe); end
        if (a_maddr !== 32'd1) begin errors++; $display("FAIL dir_load1_addr got %0h want 1", a_maddr); end
        step(1, 0, 2, 32'hAA);
        step(0, 1, 2, 0);
        checks += 2;
        if (a_ld !== 32'hAA) begin errors++; $display("FAIL dir_fwd got %0h want aa", a_ld); end
        if (mem[2] !== 32'd4) begin errors++; $display("FAIL dir_mem_before got %0h want 4", mem[2]); end
        step(0, 0, 0, 0);
        checks += 5;
        if (a_mwe !== 1'b1) begin errors++; $display("FAIL dir_drain_we got %0b want 1", a_mwe); end
        if (a_maddr !== 32'd2) begin errors++; $display("FAIL dir_drain_addr got %0h want 2", a_maddr); end
        if (a_mdin !== 32'hAA) begin errors++; $display("FAIL dir_drain_din got %0h want aa", a_mdin); end
        if (Empty !== 1'b1) begin errors++; $display("FAIL dir_empty got %0b want 1", Empty); end
        if (mem[2] !== 32'hAA) begin errors++; $display("FAIL dir_mem_after got %0h want aa", mem[2]); end
        step(1, 1, 5, 32'h11);
        step(1, 1, 5, 32'h22);
        step(0, 1, 5, 0);
        checks++;
        if (a_ld !== 32'h22) begin errors++; $display("FAIL dir_youngest got %0h want 22", a_ld); end
        step(0, 1, 37, 0);
        checks++;
        if (a_ld !== 32'h22) begin errors++; $display("FAIL dir_alias got %0h want 22", a_ld); end
        settle("dir");
        checks++;
        if (mem[5] !== 32'h22) begin errors++; $display("FAIL dir_mem5 got %0h want 22", mem[5]); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d [6];
        for (int i = 0; i < 6; i++) d[i] = $urandom;
        for (int i = 0; i < 6; i++) begin
            step(1, 1, 32'(16 + i), d[i]);
            checks++;
            if (a_stall !== (i >= 4)) begin errors++; $display("FAIL b2b_stall%0d got %0b want %0b", i, a_stall, i >= 4); end
        end
        checks++;
        if (Count !== 3'd4) begin errors++; $display("FAIL b2b_count got %0d want 4", Count); end
        for (int i = 4; i < 6; i++) begin
            int g = 0;
            do begin
                step(1, 0, 32'(16 + i), d[i]);
                g++;
            end while (a_stall && g < 10);
            checks++;
            if (a_stall) begin errors++; $display("FAIL b2b_retry%0d still stalled want accepted", i); end
        end
        settle("b2b");
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (mem[16 + i] !== d[i]) begin errors++; $display("FAIL b2b_mem%0d got %0h want %0h", 16 + i, mem[16 + i], d[i]); end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] d1 = $urandom, d2 = $urandom;
        int g = 0;
        settle("wrap_pre");
        step(1, 1, 32'd10, $urandom);
        while (pushes % 4 != 3 && g < 8) begin
            step(1, 1, 32'(11 + g), $urandom);
            g++;
        end
        while (q.size() > 1 && g < 16) begin
            step(0, 0, 0, 0);
            g++;
        end
        step(1, 0, 32'd9, d1);
        checks += 2;
        if (a_mwe !== 1'b1) begin errors++; $display("FAIL wrap_drain got %0b want 1", a_mwe); end
        if (Count !== 3'd1) begin errors++; $display("FAIL wrap_count got %0d want 1", Count); end
        step(1, 1, 32'd9, d2);
        checks++;
        if (a_ld !== d1) begin errors++; $display("FAIL wrap_fwd_old got %0h want %0h", a_ld, d1); end
        step(0, 1, 32'd41, 0);
        checks += 2;
        if (a_ld !== d2) begin errors++; $display("FAIL wrap_fwd_young got %0h want %0h", a_ld, d2); end
        if (Count !== 3'd2) begin errors++; $display("FAIL wrap_count2 got %0d want 2", Count); end
        settle("wrap");
    endtask

    task automatic test_reset_mid_drain();
        for (int i = 0; i < 4; i++) step(1, 1, 32'(24 + i), $urandom);
        step(0, 0, 0, 0);
        checks++;
        if (Count !== 3'd3) begin errors++; $display("FAIL rmd_count got %0d want 3", Count); end
        test_reset();
        for (int i = 24; i < 28; i++) begin
            checks++;
            if (mem[i] !== phys[i]) begin errors++; $display("FAIL rmd_mem%0d got %0h want %0h", i, mem[i], phys[i]); end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            logic we = $urandom_range(0, 9) < 6;
            logic re = $urandom_range(0, 9) < 4;
            step(we, re, $urandom_range(0, 63), $urandom);
            checks += 6;
            if (a_stall !== e_stall) begin errors++; $display("FAIL rnd_stall cyc%0d got %0b want %0b", n, a_stall, e_stall); end
            if (a_mwe !== e_mwe) begin errors++; $display("FAIL rnd_mem_we cyc%0d got %0b want %0b", n, a_mwe, e_mwe); end
            if (a_maddr !== e_maddr) begin errors++; $display("FAIL rnd_mem_addr cyc%0d got %0h want %0h", n, a_maddr, e_maddr); end
            if (a_mdin !== e_mdin) begin errors++; $display("FAIL rnd_mem_din cyc%0d got %0h want %0h", n, a_mdin, e_mdin); end
            if (a_count !== e_count) begin errors++; $display("FAIL rnd_count cyc%0d got %0d want %0d", n, a_count, e_count); end
            if (a_empty !== e_empty) begin errors++; $display("FAIL rnd_empty cyc%0d got %0b want %0b", n, a_empty, e_empty); end
            if (re) begin
                checks++;
                if (a_ld !== e_ld) begin errors++; $display("FAIL rnd_load cyc%0d got %0h want %0h", n, a_ld, e_ld); end
            end
        end
        settle("rnd");
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (mem[i] !== arch[i]) begin errors++; $display("FAIL rnd_mem%0d got %0h want %0h", i, mem[i], arch[i]); end
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) phys[i] = pre(i);
        init = 1;
        pushes = 0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_wrap();
        test_reset_mid_drain();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
